// File: rtl/matmul_job_queue.sv
// matmul_job_queue: bus front-end that queues matmul jobs for the systolic array, with status, done counter and scratchpad window.
// Define MATMUL_JOBQ_IRQ_EN to add the registered irq output and a read/write IRQ_MASK.
module matmul_job_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              AWVALID,
  input  logic [ADDR_W-1:0] AWADDR,
  output logic              AWREADY,
  input  logic              WDVALID,
  input  logic [DATA_W-1:0] WDATA,
  output logic              WDREADY,
  input  logic              ARVALID,
  input  logic [ADDR_W-1:0] ARADDR,
  output logic              ARREADY,
  input  logic              RDREADY,
  output logic              RDVALID,
  output logic [DATA_W-1:0] RDATA,
  output logic              sc_read_en,
  output logic              sc_write_en,
  output logic [ADDR_W-1:0] sc_addr,
  output logic [DATA_W-1:0] sc_data_in,
  input  logic [DATA_W-1:0] sc_data_out,
  input  logic              sc_ready,
  output logic              start_matmul,
  output logic [ADDR_W-1:0] input_addr,
  output logic [ADDR_W-1:0] weight_addr,
  output logic [ADDR_W-1:0] output_addr,
`ifdef MATMUL_JOBQ_IRQ_EN
  output logic              irq,
`endif
  input  logic              matmul_done
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int MSB = ADDR_W - 1;
  localparam logic [ADDR_W-2:0] OFF_X = 'h00, OFF_W = 'h04, OFF_Y = 'h08, OFF_DB = 'h0C;
  localparam logic [ADDR_W-2:0] OFF_ST = 'h10, OFF_DC = 'h14, OFF_IM = 'h18;
  typedef enum logic [1:0] {IDLE, ISSUE, RUN} state_t;
  state_t state_q, state_d;
  logic up_q, aw_v_q, w_v_q, ar_v_q, rd_v_q, sc_wr_q, sc_rd_q, ovf_q;
  logic [ADDR_W-1:0] aw_addr_q, ar_addr_q, sc_addr_q, x_q, w_q, y_q, in_q, wt_q, out_q;
  logic [DATA_W-1:0] w_data_q, sc_din_q, rdata_q, done_q, done_d, status, rd_reg;
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3*ADDR_W-1:0] mem [QDEPTH];
  logic [ADDR_W-2:0] woff, roff;
  logic [1:0] mask_rd;
  logic wr_reg, wr_sc_pend, push, push_ok, pop, full, acc, done_clr, sc_wr_go, sc_rd_go, ar_hs;
  assign AWREADY = up_q & ~aw_v_q;
  assign WDREADY = up_q & ~w_v_q;
  assign ARREADY = up_q & ~ar_v_q;
  assign RDVALID = rd_v_q;
  assign RDATA = rdata_q;
  assign sc_write_en = sc_wr_q;
  assign sc_read_en = sc_rd_q;
  assign sc_addr = sc_addr_q;
  assign sc_data_in = sc_din_q;
  assign start_matmul = state_q == ISSUE;
  assign input_addr = in_q;
  assign weight_addr = wt_q;
  assign output_addr = out_q;
  always_comb begin
    woff = aw_addr_q[MSB-1:0];
    roff = ARADDR[MSB-1:0];
    wr_reg = aw_v_q & w_v_q & ~aw_addr_q[MSB];
    wr_sc_pend = aw_v_q & w_v_q & aw_addr_q[MSB];
    full = cnt_q == CW'(QDEPTH);
    push = wr_reg & (woff == OFF_DB);
    push_ok = push & ~full;
    pop = state_q == ISSUE;
    acc = matmul_done & (state_q == RUN);
    done_clr = wr_reg & (woff == OFF_DC);
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
    done_d = done_clr ? DATA_W'(acc) : done_q + DATA_W'(acc);
    sc_wr_go = wr_sc_pend & ~sc_wr_q & ~sc_rd_q;
    sc_rd_go = ar_v_q & ar_addr_q[MSB] & ~rd_v_q & ~sc_rd_q & ~sc_wr_q & ~wr_sc_pend;
    ar_hs = ARVALID & ARREADY;
    status = '0;
    status[8:0] = 9'(cnt_q);
    status[9] = full;
    status[10] = state_q != IDLE;
    status[11] = ovf_q;
    rd_reg = roff == OFF_X ? DATA_W'(x_q) : roff == OFF_W ? DATA_W'(w_q) :
             roff == OFF_Y ? DATA_W'(y_q) : roff == OFF_ST ? status :
             roff == OFF_DC ? done_q : roff == OFF_IM ? DATA_W'(mask_rd) : '0;
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && cnt_q != '0) state_d = ISSUE;
    if (state_q == ISSUE) state_d = RUN;
    if (acc) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk)
    if (push_ok) mem[wp_q] <= {x_q, w_q, y_q};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {up_q, aw_v_q, w_v_q, ar_v_q, rd_v_q, sc_wr_q, sc_rd_q, ovf_q} <= '0;
      {aw_addr_q, ar_addr_q, sc_addr_q, x_q, w_q, y_q, in_q, wt_q, out_q} <= '0;
      {w_data_q, sc_din_q, rdata_q, done_q} <= '0;
      {wp_q, rp_q, cnt_q} <= '0;
    end else begin
      up_q <= 1'b1;
      if (AWVALID && AWREADY) begin
        aw_v_q <= 1'b1;
        aw_addr_q <= AWADDR;
      end
      if (WDVALID && WDREADY) begin
        w_v_q <= 1'b1;
        w_data_q <= WDATA;
      end
      if (wr_reg || (sc_wr_q && sc_ready)) begin
        aw_v_q <= 1'b0;
        w_v_q <= 1'b0;
      end
      if (wr_reg && woff == OFF_X) x_q <= ADDR_W'(w_data_q);
      if (wr_reg && woff == OFF_W) w_q <= ADDR_W'(w_data_q);
      if (wr_reg && woff == OFF_Y) y_q <= ADDR_W'(w_data_q);
      if (wr_reg && woff == OFF_ST && w_data_q[11]) ovf_q <= 1'b0;
      // a doorbell on a full queue is dropped even when a pop happens this cycle
      if (push && full) ovf_q <= 1'b1;
      if (push_ok) wp_q <= wp_q + PW'(1);
      if (pop) rp_q <= rp_q + PW'(1);
      cnt_q <= cnt_d;
      done_q <= done_d;
      if (state_q == IDLE && state_d == ISSUE) {in_q, wt_q, out_q} <= mem[rp_q];
      if (sc_wr_go) begin
        sc_wr_q <= 1'b1;
        sc_addr_q <= {1'b0, aw_addr_q[MSB-1:0]};
        sc_din_q <= w_data_q;
      end else if (sc_wr_q && sc_ready) sc_wr_q <= 1'b0;
      if (sc_rd_go) begin
        sc_rd_q <= 1'b1;
        sc_addr_q <= {1'b0, ar_addr_q[MSB-1:0]};
      end else if (sc_rd_q && sc_ready) begin
        sc_rd_q <= 1'b0;
        rd_v_q <= 1'b1;
        rdata_q <= sc_data_out;
      end
      // register reads are answered straight from the handshake for one-cycle latency
      if (ar_hs) begin
        ar_v_q <= 1'b1;
        ar_addr_q <= ARADDR;
        if (!ARADDR[MSB]) begin
          rd_v_q <= 1'b1;
          rdata_q <= rd_reg;
        end
      end else if (rd_v_q && RDREADY) begin
        rd_v_q <= 1'b0;
        ar_v_q <= 1'b0;
      end
    end
`ifdef MATMUL_JOBQ_IRQ_EN
  logic [1:0] mask_q;
  logic irq_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mask_q <= '0;
      irq_q <= 1'b0;
    end else begin
      if (wr_reg && woff == OFF_IM) mask_q <= w_data_q[1:0];
      irq_q <= (mask_q[0] & (done_q != '0)) | (mask_q[1] & ovf_q);
    end
  assign irq = irq_q;
  assign mask_rd = mask_q;
`else
  assign mask_rd = 2'b00;
`endif
endmodule

// File: tb/tb_matmul_job_queue.sv
// tb_matmul_job_queue: register-vector table plus hand sequences; issued jobs checked against a scoreboard queue.
module tb_matmul_job_queue;
  logic clk = 0, rst = 1;
  logic AWVALID = 0, WDVALID = 0, ARVALID = 0, RDREADY = 0, sc_ready = 0, matmul_done = 0;
  logic [31:0] AWADDR = 0, WDATA = 0, ARADDR = 0, sc_data_out = 0;
  logic AWREADY, WDREADY, ARREADY, RDVALID, sc_read_en, sc_write_en, start_matmul;
  logic [31:0] RDATA, sc_addr, sc_data_in, input_addr, weight_addr, output_addr;
`ifdef MATMUL_JOBQ_IRQ_EN
  logic irq;
  localparam logic [31:0] IRQ_EXP = 32'h3;
`else
  localparam logic [31:0] IRQ_EXP = 32'h0;
`endif
  int n_vec = 0, n_err = 0, n_starts = 0, sc_delay = 1, sc_cyc = 0, sc_we_cycles = 0;
  logic [31:0] sc_last_addr = 0, rd;
  logic [31:0] spm [16];
  logic [95:0] exp_q [$];
  logic [95:0] exp_job;
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t tbl [10];

  matmul_job_queue dut (
    .clk(clk), .rst(rst),
    .AWVALID(AWVALID), .AWADDR(AWADDR), .AWREADY(AWREADY),
    .WDVALID(WDVALID), .WDATA(WDATA), .WDREADY(WDREADY),
    .ARVALID(ARVALID), .ARADDR(ARADDR), .ARREADY(ARREADY),
    .RDREADY(RDREADY), .RDVALID(RDVALID), .RDATA(RDATA),
    .sc_read_en(sc_read_en), .sc_write_en(sc_write_en), .sc_addr(sc_addr),
    .sc_data_in(sc_data_in), .sc_data_out(sc_data_out), .sc_ready(sc_ready),
    .start_matmul(start_matmul), .input_addr(input_addr), .weight_addr(weight_addr),
    .output_addr(output_addr),
`ifdef MATMUL_JOBQ_IRQ_EN
    .irq(irq),
`endif
    .matmul_done(matmul_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // scratchpad model: completes each access after sc_delay strobe cycles
  always @(negedge clk) begin
    if (sc_ready) begin
      sc_ready = 0;
      sc_cyc = 0;
    end else if (sc_write_en || sc_read_en) begin
      if (sc_write_en) sc_we_cycles++;
      sc_cyc++;
      if (sc_cyc >= sc_delay) begin
        sc_ready = 1;
        sc_last_addr = sc_addr;
        if (sc_write_en) spm[sc_addr[5:2]] = sc_data_in;
        else sc_data_out = spm[sc_addr[5:2]];
      end
    end
  end

  always @(negedge clk)
    if (start_matmul) begin
      n_starts++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL start_unexpected: got start X=%h W=%h Y=%h, required no start", input_addr, weight_addr, output_addr);
      end else begin
        exp_job = exp_q.pop_front();
        check("job_operands", {input_addr, weight_addr, output_addr}, exp_job);
      end
    end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    int t = 0;
    AWADDR = a;
    WDATA = d;
    AWVALID = 1;
    WDVALID = 1;
    while ((AWVALID || WDVALID) && t < 50) begin
      logic aw_hs, w_hs;
      aw_hs = AWREADY;
      w_hs = WDREADY;
      @(negedge clk);
      if (aw_hs) AWVALID = 0;
      if (w_hs) WDVALID = 0;
      t++;
    end
    if (AWVALID || WDVALID) begin
      n_err++;
      $display("FAIL wr_handshake addr %h: got no READY, required READY", a);
      AWVALID = 0;
      WDVALID = 0;
    end
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    int t = 0;
    ARADDR = a;
    ARVALID = 1;
    while (ARVALID && t < 50) begin
      logic hs;
      hs = ARREADY;
      @(negedge clk);
      if (hs) ARVALID = 0;
      t++;
    end
    ARVALID = 0;
    t = 0;
    while (!RDVALID && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!RDVALID) begin
      n_err++;
      $display("FAIL rd_timeout addr %h: got no RDVALID, required RDVALID", a);
    end
    d = RDATA;
    RDREADY = 1;
    @(negedge clk);
    RDREADY = 0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic doorbell(input logic [31:0] x, input logic [31:0] w, input logic [31:0] y, input logic accept);
    bus_write(32'h00, x);
    bus_write(32'h04, w);
    bus_write(32'h08, y);
    if (accept) exp_q.push_back({x, w, y});
    bus_write(32'h0C, 32'h0);
  endtask

  task automatic wait_start();
    int t = 0;
    while (!start_matmul && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("start_seen", start_matmul, 1);
    @(negedge clk);
  endtask

  task automatic pulse_done();
    matmul_done = 1;
    @(negedge clk);
    matmul_done = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required end within time limit");
    $fatal(1);
  end

  initial begin
    int s0;
    tbl[0] = '{1'b1, 32'h00, 32'h100, 32'h100, "x_stage"};
    tbl[1] = '{1'b1, 32'h04, 32'h200, 32'h200, "w_stage"};
    tbl[2] = '{1'b1, 32'h08, 32'h300, 32'h300, "y_stage"};
    tbl[3] = '{1'b0, 32'h10, 32'h0, 32'h0, "status_idle"};
    tbl[4] = '{1'b0, 32'h14, 32'h0, 32'h0, "done_count_rst"};
    tbl[5] = '{1'b1, 32'h40, 32'h1234, 32'h0, "unmapped"};
    tbl[6] = '{1'b1, 32'h18, 32'h3, IRQ_EXP, "irq_mask"};
    tbl[7] = '{1'b1, 32'h8000_0004, 32'hCAFE_F00D, 32'hCAFE_F00D, "spm_rw"};
    tbl[8] = '{1'b1, 32'h10, 32'h5, 32'h0, "status_ro"};
    tbl[9] = '{1'b1, 32'h14, 32'h77, 32'h0, "done_wr_clears"};
    for (int i = 0; i < 16; i++) spm[i] = 0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {AWREADY, WDREADY, ARREADY, RDVALID, start_matmul, sc_write_en, sc_read_en}, 0);
    check("rst_data", {RDATA, input_addr, sc_addr}, 0);
    rst = 0;
    #1 check("ready_before_edge", {AWREADY, WDREADY, ARREADY}, 0);
    @(negedge clk);
    check("ready_after_edge", {AWREADY, WDREADY, ARREADY}, 3'b111);
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].data);
      rd_chk(tbl[i].name, tbl[i].addr, tbl[i].exp);
    end
    // single job
    doorbell(32'h100, 32'h200, 32'h300, 1);
    wait_start();
    rd_chk("status_run", 32'h10, 32'h400);
    pulse_done();
    rd_chk("done_one", 32'h14, 32'h1);
    rd_chk("status_after_job", 32'h10, 32'h0);
    pulse_done();
    rd_chk("done_ignored_idle", 32'h14, 32'h1);
    // overflow with the array held in RUN
    bus_write(32'h14, 32'h0);
    s0 = n_starts;
    for (int i = 0; i < 6; i++)
      doorbell(32'h1000 + i, 32'h2000 + i, 32'h3000 + i, i < 5);
    rd_chk("status_full_ovf", 32'h10, 32'hE04);
    for (int i = 0; i < 5; i++) begin
      pulse_done();
      repeat (4) @(negedge clk);
    end
    check("ovf_starts", n_starts - s0, 5);
    check("ovf_scoreboard_empty", exp_q.size(), 0);
    rd_chk("done_five", 32'h14, 32'h5);
    bus_write(32'h10, 32'h800);
    rd_chk("ovf_cleared", 32'h10, 32'h0);
    // scratchpad write with slow ready, then held read
    sc_delay = 3;
    sc_we_cycles = 0;
    bus_write(32'h8000_0010, 32'hDEAD_BEEF);
    repeat (6) @(negedge clk);
    check("sc_we_cycles", sc_we_cycles, 3);
    check("sc_addr_msb_clear", sc_last_addr, 32'h10);
    ARADDR = 32'h8000_0010;
    ARVALID = 1;
    @(negedge clk);
    ARVALID = 0;
    for (int t = 0; t < 20 && !RDVALID; t++) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("sc_rd_hold", {RDVALID, RDATA}, {1'b1, 32'hDEAD_BEEF});
      @(negedge clk);
    end
    RDREADY = 1;
    @(negedge clk);
    RDREADY = 0;
    check("sc_rd_released", RDVALID, 0);
    sc_delay = 1;
    // register read latency
    ARADDR = 32'h14;
    ARVALID = 1;
    @(negedge clk);
    ARVALID = 0;
    check("rd_latency", {RDVALID, RDATA}, {1'b1, 32'h5});
    RDREADY = 1;
    @(negedge clk);
    RDREADY = 0;
    // DONE_COUNT clear retiring in the same cycle as an accepted done
    doorbell(32'hA, 32'hB, 32'hC, 1);
    wait_start();
    AWADDR = 32'h14;
    WDATA = 32'h0;
    AWVALID = 1;
    WDVALID = 1;
    @(negedge clk);
    AWVALID = 0;
    WDVALID = 0;
    matmul_done = 1;
    @(negedge clk);
    matmul_done = 0;
    @(negedge clk);
    rd_chk("clear_with_done", 32'h14, 32'h1);
    // reset during RUN with two jobs queued
    doorbell(32'h11, 32'h22, 32'h33, 1);
    doorbell(32'h44, 32'h55, 32'h66, 0);
    doorbell(32'h77, 32'h88, 32'h99, 0);
    rd_chk("status_two_queued", 32'h10, 32'h402);
    s0 = n_starts;
    #2 rst = 1;
    #1 check("async_rst_outputs", {start_matmul, AWREADY, input_addr, weight_addr}, 0);
    @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    check("no_start_after_rst", n_starts - s0, 0);
    rd_chk("status_after_rst", 32'h10, 32'h0);
`ifdef MATMUL_JOBQ_IRQ_EN
    bus_write(32'h18, 32'h1);
    doorbell(32'h1, 32'h2, 32'h3, 1);
    wait_start();
    pulse_done();
    repeat (2) @(negedge clk);
    check("irq_set", irq, 1);
    bus_write(32'h14, 32'h0);
    check("irq_lag", irq, 1);
    @(negedge clk);
    check("irq_cleared", irq, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
